// File: rtl/cpu_bus_pkg.sv
// rtl/cpu_bus_pkg.sv - shared CPU bus source indices, default sizes and popcount helper
package cpu_bus_pkg;

  localparam int DEF_N_SRC = 24;
  localparam int DEF_WIDTH = 32;

  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_MDR    = 16;
  localparam int SRC_HI     = 17;
  localparam int SRC_LO     = 18;
  localparam int SRC_ZHI    = 19;
  localparam int SRC_ZLO    = 20;
  localparam int SRC_PC     = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  function automatic logic popcount_gt1(input logic [63:0] v);
    return (v & (v - 64'd1)) != 64'd0;
  endfunction

endpackage

// File: rtl/bus_arb_mux_if.sv
// rtl/bus_arb_mux_if.sv - source/bus signal bundle for bus_arb_mux
interface bus_arb_mux_if #(
  parameter int N_SRC = cpu_bus_pkg::DEF_N_SRC,
  parameter int WIDTH = cpu_bus_pkg::DEF_WIDTH
) ();
  localparam int SRC_W = $clog2(N_SRC);

  logic [N_SRC-1:0]       src_en;
  logic [N_SRC*WIDTH-1:0] src_data;
  logic                   clr_err;
  logic [WIDTH-1:0]       bus_out;
  logic                   bus_valid;
  logic [SRC_W-1:0]       bus_src;
  logic [N_SRC-1:0]       grant;
  logic                   collision;
  logic                   err_sticky;

  modport master (
    output src_en, src_data, clr_err,
    input  bus_out, bus_valid, bus_src, grant, collision, err_sticky
  );

  modport slave (
    input  src_en, src_data, clr_err,
    output bus_out, bus_valid, bus_src, grant, collision, err_sticky
  );
endinterface

// File: rtl/bus_arb_pick.sv
// rtl/bus_arb_pick.sv - combinational winner select; round-robin when BUS_RR_ARB_EN is defined
module bus_arb_pick #(
  parameter int N_SRC = cpu_bus_pkg::DEF_N_SRC,
  parameter int SRC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] src_en,
  input  logic [SRC_W-1:0] rr_ptr,
  output logic [SRC_W-1:0] win_idx,
  output logic             any_en
);

  assign any_en = |src_en;

`ifdef BUS_RR_ARB_EN
  // Walk from rr_ptr upward, wrapping at N_SRC; the first enabled source wins.
  always_comb begin
    logic             found;
    logic [SRC_W:0]   j;
    found   = 1'b0;
    win_idx = '0;
    j       = '0;
    for (int k = 0; k < N_SRC; k++) begin
      j = {1'b0, rr_ptr} + (SRC_W+1)'(k);
      if (j >= (SRC_W+1)'(N_SRC)) j = j - (SRC_W+1)'(N_SRC);
      if (!found && src_en[j[SRC_W-1:0]]) begin
        win_idx = j[SRC_W-1:0];
        found   = 1'b1;
      end
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^rr_ptr;

  // Later sources override earlier ones, so the highest enabled index wins.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (src_en[i]) win_idx = SRC_W'(i);
    end
  end
`endif

endmodule

// File: rtl/bus_arb_mux.sv
// rtl/bus_arb_mux.sv - registered single-winner bus mux with collision report; BUS_RR_ARB_EN selects round-robin
module bus_arb_mux #(
  parameter int N_SRC = cpu_bus_pkg::DEF_N_SRC,
  parameter int WIDTH = cpu_bus_pkg::DEF_WIDTH
) (
  input  logic          clock,
  input  logic          clear_n,
  bus_arb_mux_if.slave  bus
);
  import cpu_bus_pkg::*;

  localparam int SRC_W = $clog2(N_SRC);

  logic [SRC_W-1:0] win_idx;
  logic [SRC_W-1:0] rr_ptr;
  logic             any_en;
  logic [WIDTH-1:0] win_data;
  logic             multi_en;

  bus_arb_pick #(.N_SRC(N_SRC), .SRC_W(SRC_W)) u_pick (
    .src_en  (bus.src_en),
    .rr_ptr  (rr_ptr),
    .win_idx (win_idx),
    .any_en  (any_en)
  );

`ifdef BUS_RR_ARB_EN
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      rr_ptr <= '0;
    end else if (any_en) begin
      rr_ptr <= (win_idx == SRC_W'(N_SRC - 1)) ? '0 : win_idx + 1'b1;
    end
  end
`else
  assign rr_ptr = '0;
`endif

  assign win_data = bus.src_data[int'(win_idx)*WIDTH +: WIDTH];
  assign multi_en = popcount_gt1(64'(bus.src_en));

  // Data and index hold while idle; only valid and grant drop.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      bus.bus_out    <= '0;
      bus.bus_valid  <= 1'b0;
      bus.bus_src    <= '0;
      bus.grant      <= '0;
      bus.collision  <= 1'b0;
      bus.err_sticky <= 1'b0;
    end else begin
      bus.collision <= multi_en;
      if (multi_en)         bus.err_sticky <= 1'b1;
      else if (bus.clr_err) bus.err_sticky <= 1'b0;
      if (any_en) begin
        bus.bus_out   <= win_data;
        bus.bus_valid <= 1'b1;
        bus.bus_src   <= win_idx;
        bus.grant     <= N_SRC'(1) << win_idx;
      end else begin
        bus.bus_valid <= 1'b0;
        bus.grant     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bus_arb_mux.sv
// tb/tb_bus_arb_mux.sv - directed vector bench for bus_arb_mux (N_SRC=24, WIDTH=32)
module tb_bus_arb_mux;

  typedef struct {
    logic [23:0] en;
    logic        clr;
    logic [31:0] out;
    logic        v;
    logic [4:0]  src;
    logic [23:0] g;
    logic        c;
    logic        e;
  } vec_t;

  logic clk = 1'b0;
  logic clear_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl [9];

  always #5 clk = ~clk;

  bus_arb_mux_if #(.N_SRC(24), .WIDTH(32)) bus ();

  bus_arb_mux #(.N_SRC(24), .WIDTH(32)) dut (
    .clock   (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  function automatic vec_t mk(input logic [23:0] en, input logic clr, input logic [31:0] out,
                              input logic v, input logic [4:0] src, input logic [23:0] g,
                              input logic c, input logic e);
    vec_t r;
    r.en = en; r.clr = clr; r.out = out; r.v = v; r.src = src; r.g = g; r.c = c; r.e = e;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] out, input logic v, input logic [4:0] src,
                         input logic [23:0] g, input logic c, input logic e);
    chk({tag, ".bus_out"},    64'(bus.bus_out),    64'(out));
    chk({tag, ".bus_valid"},  64'(bus.bus_valid),  64'(v));
    chk({tag, ".bus_src"},    64'(bus.bus_src),    64'(src));
    chk({tag, ".grant"},      64'(bus.grant),      64'(g));
    chk({tag, ".collision"},  64'(bus.collision),  64'(c));
    chk({tag, ".err_sticky"}, 64'(bus.err_sticky), 64'(e));
  endtask

  task automatic cyc(input logic [23:0] en, input logic clr);
    @(negedge clk);
    bus.src_en  = en;
    bus.clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    bus.src_en  = '0;
    bus.clr_err = 1'b0;
    clear_n     = 1'b0;
    #2;
    clear_n     = 1'b1;
  endtask

  initial begin
    clear_n      = 1'b0;
    bus.src_en   = '0;
    bus.clr_err  = 1'b0;
    for (int i = 0; i < 24; i++) bus.src_data[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);

    tbl[0] = mk(24'h1 << 21, 1'b0, 32'hA5A5_0015, 1'b1, 5'd21, 24'h1 << 21, 1'b0, 1'b0);
    tbl[1] = mk(24'h0,       1'b0, 32'hA5A5_0015, 1'b0, 5'd21, 24'h0,       1'b0, 1'b0);
    tbl[2] = mk(24'h1,       1'b0, 32'hA5A5_0000, 1'b1, 5'd0,  24'h1,       1'b0, 1'b0);
`ifdef BUS_RR_ARB_EN
    tbl[3] = mk(24'h24,      1'b0, 32'hA5A5_0002, 1'b1, 5'd2,  24'h4,       1'b1, 1'b1);
    tbl[4] = mk(24'h0,       1'b0, 32'hA5A5_0002, 1'b0, 5'd2,  24'h0,       1'b0, 1'b1);
    tbl[5] = mk(24'h0,       1'b1, 32'hA5A5_0002, 1'b0, 5'd2,  24'h0,       1'b0, 1'b0);
    tbl[6] = mk(24'hC00002,  1'b1, 32'hA5A5_0016, 1'b1, 5'd22, 24'h400000,  1'b1, 1'b1);
    tbl[7] = mk(24'h800000,  1'b1, 32'hA5A5_0017, 1'b1, 5'd23, 24'h800000,  1'b0, 1'b0);
    tbl[8] = mk(24'hFFFFFF,  1'b0, 32'hA5A5_0000, 1'b1, 5'd0,  24'h1,       1'b1, 1'b1);
`else
    tbl[3] = mk(24'h24,      1'b0, 32'hA5A5_0005, 1'b1, 5'd5,  24'h20,      1'b1, 1'b1);
    tbl[4] = mk(24'h0,       1'b0, 32'hA5A5_0005, 1'b0, 5'd5,  24'h0,       1'b0, 1'b1);
    tbl[5] = mk(24'h0,       1'b1, 32'hA5A5_0005, 1'b0, 5'd5,  24'h0,       1'b0, 1'b0);
    tbl[6] = mk(24'hC00002,  1'b1, 32'hA5A5_0017, 1'b1, 5'd23, 24'h800000,  1'b1, 1'b1);
    tbl[7] = mk(24'h800000,  1'b1, 32'hA5A5_0017, 1'b1, 5'd23, 24'h800000,  1'b0, 1'b0);
    tbl[8] = mk(24'hFFFFFF,  1'b0, 32'hA5A5_0017, 1'b1, 5'd23, 24'h800000,  1'b1, 1'b1);
`endif

    #2;
    chk_all("reset0", 32'h0, 1'b0, 5'd0, 24'h0, 1'b0, 1'b0);
    @(negedge clk);
    clear_n = 1'b1;

    for (int k = 0; k < 9; k++) begin
      cyc(tbl[k].en, tbl[k].clr);
      chk_all($sformatf("vec%0d", k), tbl[k].out, tbl[k].v, tbl[k].src, tbl[k].g, tbl[k].c, tbl[k].e);
    end

    // Reset asserted between edges while the bus is busy.
    cyc(24'h1 << 21, 1'b0);
    #2;
    clear_n = 1'b0;
    #1;
    chk_all("rst_mid", 32'h0, 1'b0, 5'd0, 24'h0, 1'b0, 1'b0);
    @(negedge clk);
    clear_n = 1'b1;
    cyc(24'h9, 1'b0);
`ifdef BUS_RR_ARB_EN
    chk_all("rst_first", 32'hA5A5_0000, 1'b1, 5'd0, 24'h1, 1'b1, 1'b1);
`else
    chk_all("rst_first", 32'hA5A5_0003, 1'b1, 5'd3, 24'h8, 1'b1, 1'b1);
`endif
    cyc(24'h0, 1'b1);
    chk("rst_clr.err_sticky", 64'(bus.err_sticky), 64'd0);

    // PC drives alone, then three idle cycles hold the value.
    bus.src_data[21*32 +: 32] = 32'h0000_0104;
    cyc(24'h1 << 21, 1'b0);
    chk_all("pc", 32'h0000_0104, 1'b1, 5'd21, 24'h1 << 21, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(24'h0, 1'b0);
      chk_all($sformatf("idle%0d", k), 32'h0000_0104, 1'b0, 5'd21, 24'h0, 1'b0, 1'b0);
    end

    // R2 and R5 collide.
    bus.src_data[2*32 +: 32] = 32'hAAAA_0002;
    bus.src_data[5*32 +: 32] = 32'h5555_0005;
    cyc(24'h24, 1'b0);
`ifdef BUS_RR_ARB_EN
    chk_all("coll", 32'hAAAA_0002, 1'b1, 5'd2, 24'h4, 1'b1, 1'b1);
`else
    chk_all("coll", 32'h5555_0005, 1'b1, 5'd5, 24'h20, 1'b1, 1'b1);
`endif
    cyc(24'h0, 1'b1);
    chk("coll_clr.collision",  64'(bus.collision),  64'd0);
    chk("coll_clr.err_sticky", 64'(bus.err_sticky), 64'd0);
    cyc(24'h24, 1'b1);
    chk_all("coll_setclr", 32'h5555_0005, 1'b1, 5'd5, 24'h20, 1'b1, 1'b1);
    cyc(24'h0, 1'b0);
    chk("coll_after.collision",  64'(bus.collision),  64'd0);
    chk("coll_after.err_sticky", 64'(bus.err_sticky), 64'd1);

    // Three contenders held for six cycles from a fresh pointer.
    pulse_reset();
    for (int k = 0; k < 6; k++) begin
      logic [4:0] exp_src;
`ifdef BUS_RR_ARB_EN
      exp_src = (k % 3 == 0) ? 5'd0 : (k % 3 == 1) ? 5'd3 : 5'd23;
`else
      exp_src = 5'd23;
`endif
      cyc(24'h800009, 1'b0);
      chk($sformatf("rr%0d.bus_src", k), 64'(bus.bus_src), 64'(exp_src));
      chk($sformatf("rr%0d.grant", k),   64'(bus.grant),   64'(24'h1 << exp_src));
    end

    // Pointer wraps from the last source back to source 0.
    cyc(24'h800000, 1'b0);
    chk("wrap_a.bus_src", 64'(bus.bus_src), 64'd23);
    cyc(24'h800001, 1'b0);
`ifdef BUS_RR_ARB_EN
    chk("wrap_b.bus_src", 64'(bus.bus_src), 64'd0);
`else
    chk("wrap_b.bus_src", 64'(bus.bus_src), 64'd23);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
